// File: rtl/cte_param.sv
// Colour-space converter: YUV422 byte stream -> RGB pixels (mode 0) or
// RGB pixels -> YUV422 byte stream through a small output FIFO (mode 1).
module cte_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_mode,
  input  logic            in_en,
  input  logic [DW-1:0]   yuv_in,
  input  logic [3*DW-1:0] rgb_in,
  output logic            busy,
  output logic            out_valid,
  output logic [3*DW-1:0] rgb_out,
  output logic [DW-1:0]   yuv_out
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int OFF  = 1 << (DW - 1);
  localparam int MAXV = (1 << DW) - 1;

  // Handshake: a byte/pixel is consumed on a rising edge where in_en=1 and
  // busy=0; busy is combinational and never depends on in_en.

  function automatic logic [DW-1:0] clamp(input int v);
    if (v < 0) return '0;
    if (v > MAXV) return DW'(MAXV);
    return DW'(v);
  endfunction

  function automatic logic [3*DW-1:0] yuv2rgb(input logic [DW-1:0] u,
                                              input logic [DW-1:0] y,
                                              input logic [DW-1:0] v);
    int d, e, yy;
    d  = int'(u) - OFF;
    e  = int'(v) - OFF;
    yy = int'(y);
    return {clamp(yy + ((359 * e + 128) >>> 8)),
            clamp(yy + ((-88 * d - 183 * e + 128) >>> 8)),
            clamp(yy + ((454 * d + 128) >>> 8))};
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic            mode_q;
  logic [1:0]      phase_q;
  logic [DW-1:0]   u_q, y0_q, v_q;
  logic            rgb_valid_q;
  logic [3*DW-1:0] rgb_q;
  logic            stage_valid_q, stage_odd_q;
  logic [3*DW-1:0] stage_pix_q;
  logic [DW-1:0]   v1_q;
  logic [DW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            mode_change, xfer, push, pop;
  logic [CW:0]     fill;
  int              r_i, g_i, b_i;
  logic [DW-1:0]   y_c, u_c, v_c, push_a;

  assign mode_change = (op_mode != mode_q);
  assign fill        = {1'b0, count_q} + (CW+1)'({stage_valid_q, 1'b0});
  assign busy        = !reset && (mode_change ||
                                  (mode_q && (fill >= (CW+1)'(DEPTH - 1))));
  assign xfer        = in_en && !busy;
  assign push        = stage_valid_q;
  assign pop         = (count_q != '0);

  assign out_valid = mode_q ? pop : rgb_valid_q;
  assign rgb_out   = mode_q ? '0 : rgb_q;
  assign yuv_out   = (mode_q && pop) ? fifo_mem[rd_ptr_q] : '0;

  // Mode-1 conversion of the staged pixel; U/V of odd pixels are ignored.
  always_comb begin
    r_i    = int'(stage_pix_q[3*DW-1 -: DW]);
    g_i    = int'(stage_pix_q[2*DW-1 -: DW]);
    b_i    = int'(stage_pix_q[DW-1:0]);
    y_c    = clamp((77 * r_i + 150 * g_i + 29 * b_i + 128) >>> 8);
    u_c    = clamp(((-43 * r_i - 85 * g_i + 128 * b_i + 128) >>> 8) + OFF);
    v_c    = clamp(((128 * r_i - 107 * g_i - 21 * b_i + 128) >>> 8) + OFF);
    push_a = stage_odd_q ? v1_q : u_c;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q]      <= push_a;
      fifo_mem[nxt(wr_ptr_q)] <= y_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= op_mode;
      phase_q       <= '0;
      u_q           <= '0;
      y0_q          <= '0;
      v_q           <= '0;
      rgb_valid_q   <= 1'b0;
      rgb_q         <= '0;
      stage_valid_q <= 1'b0;
      stage_odd_q   <= 1'b0;
      stage_pix_q   <= '0;
      v1_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      rgb_valid_q   <= 1'b0;
      rgb_q         <= '0;
      stage_valid_q <= 1'b0;
      // A new mode only takes effect on a pixel boundary with nothing in flight.
      if (mode_change && phase_q == 2'd0 && !stage_valid_q &&
          count_q == '0 && !rgb_valid_q)
        mode_q <= op_mode;
      if (xfer) begin
        if (!mode_q) begin
          case (phase_q)
            2'd0: u_q  <= yuv_in;
            2'd1: y0_q <= yuv_in;
            2'd2: begin
              v_q         <= yuv_in;
              rgb_q       <= yuv2rgb(u_q, y0_q, yuv_in);
              rgb_valid_q <= 1'b1;
            end
            default: begin
              rgb_q       <= yuv2rgb(u_q, yuv_in, v_q);
              rgb_valid_q <= 1'b1;
            end
          endcase
          phase_q <= phase_q + 2'd1;
        end else begin
          stage_valid_q <= 1'b1;
          stage_pix_q   <= rgb_in;
          stage_odd_q   <= phase_q[0];
          phase_q       <= phase_q[0] ? 2'd0 : 2'd1;
        end
      end
      if (push && !stage_odd_q) v1_q <= v_c;
      if (push) wr_ptr_q <= nxt(nxt(wr_ptr_q));
      if (pop)  rd_ptr_q <= nxt(rd_ptr_q);
      count_q <= count_q + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

endmodule

// File: tb/tb_cte_param.sv
// Bench for cte_param: directed vectors plus randomized streams in both modes,
// checked against a pixel-level reference model with an expected-byte queue.
module tb_cte_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, op_mode, in_en;
  logic [DW-1:0]   yuv_in;
  logic [3*DW-1:0] rgb_in;
  logic            busy, out_valid;
  logic [3*DW-1:0] rgb_out;
  logic [DW-1:0]   yuv_out;

  cte_param #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op_mode(op_mode), .in_en(in_en),
    .yuv_in(yuv_in), .rgb_in(rgb_in), .busy(busy), .out_valid(out_valid),
    .rgb_out(rgb_out), .yuv_out(yuv_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard state
  logic [DW-1:0]   exp_q[$];
  logic [3*DW-1:0] obs_rgb_q[$];
  logic [DW-1:0]   obs_yuv_q[$];
  int              obs_cyc_q[$];
  bit              pend_rgb;
  logic [3*DW-1:0] pend_val;
  int              mphase;
  bit              model_mode;
  logic [DW-1:0]   mu, my0, mv, mv1;
  int              busy_toggles;
  bit              prev_busy;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic [DW-1:0] sat(input int v);
    if (v < 0) return '0;
    if (v > 255) return 8'hFF;
    return DW'(v);
  endfunction

  function automatic logic [3*DW-1:0] ref_rgb(input logic [DW-1:0] u,
                                              input logic [DW-1:0] y,
                                              input logic [DW-1:0] v);
    int d, e, yy;
    d  = int'(u) - 128;
    e  = int'(v) - 128;
    yy = int'(y);
    return {sat(yy + ((359 * e + 128) >>> 8)),
            sat(yy + ((-88 * d - 183 * e + 128) >>> 8)),
            sat(yy + ((454 * d + 128) >>> 8))};
  endfunction

  task automatic ref_yuv(input logic [3*DW-1:0] p, output logic [DW-1:0] y,
                         output logic [DW-1:0] u, output logic [DW-1:0] v);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = sat((77 * r + 150 * g + 29 * b + 128) >>> 8);
    u = sat(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
    v = sat(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
  endtask

  task automatic accept();
    logic [DW-1:0] y, u, v;
    model_mode = op_mode;
    if (!op_mode) begin
      case (mphase)
        0: mu = yuv_in;
        1: my0 = yuv_in;
        2: begin mv = yuv_in; pend_rgb = 1; pend_val = ref_rgb(mu, my0, yuv_in); end
        default: begin pend_rgb = 1; pend_val = ref_rgb(mu, yuv_in, mv); end
      endcase
      mphase = (mphase + 1) % 4;
    end else begin
      ref_yuv(rgb_in, y, u, v);
      if (mphase == 0) begin
        exp_q.push_back(u);
        exp_q.push_back(y);
        mv1    = v;
        mphase = 1;
      end else begin
        exp_q.push_back(mv1);
        exp_q.push_back(y);
        mphase = 0;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, record any transfer.
  task automatic tick(output bit took);
    @(negedge clk);
    cyc++;
    if (pend_rgb) begin
      check("rgb_valid", out_valid, 1);
      check("rgb_out", rgb_out, pend_val);
      check("yuv_out_zero", yuv_out, 0);
      obs_rgb_q.push_back(rgb_out);
    end else if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", out_valid, 0);
      else begin
        check("yuv_out", yuv_out, exp_q.pop_front());
        check("rgb_out_zero", rgb_out, 0);
        obs_yuv_q.push_back(yuv_out);
        obs_cyc_q.push_back(cyc);
      end
    end
    pend_rgb = 0;
    if (!op_mode && !model_mode) check("busy_m0", busy, 0);
    if (busy != prev_busy) busy_toggles++;
    prev_busy = busy;
    took = in_en && !busy;
    if (took) accept();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic idle(input int n);
    bit t;
    in_en = 1'b0;
    repeat (n) tick(t);
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    bit took;
    int n = 0;
    yuv_in = b;
    in_en  = 1'b1;
    do begin tick(took); n++; end while (!took && n < 50);
    if (!took) check("byte_accept_timeout", took, 1);
  endtask

  task automatic send_pix(input logic [3*DW-1:0] p);
    bit took;
    int n = 0;
    rgb_in = p;
    in_en  = 1'b1;
    do begin tick(took); n++; end while (!took && n < 50);
    if (!took) check("pix_accept_timeout", took, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_en = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_rgb_out", rgb_out, 0);
    check("rst_yuv_out", yuv_out, 0);
    check("rst_busy", busy, 0);
    exp_q.delete();
    pend_rgb   = 0;
    mphase     = 0;
    model_mode = op_mode;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rgb_log(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b);
    check("rgb_log_len", obs_rgb_q.size(), 2);
    if (obs_rgb_q.size() == 2) begin
      check("rgb_log_px0", obs_rgb_q[0], a);
      check("rgb_log_px1", obs_rgb_q[1], b);
    end
    obs_rgb_q.delete();
  endtask

  task automatic check_yuv_log(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                               input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    logic [DW-1:0] e[4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    check("yuv_log_len", obs_yuv_q.size(), 4);
    if (obs_yuv_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("yuv_log_byte", obs_yuv_q[i], e[i]);
        if (i > 0) check("yuv_log_gap", obs_cyc_q[i] - obs_cyc_q[i-1], 1);
      end
    obs_yuv_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    int n;
    op_mode = 1'b0;
    in_en   = 1'b0;
    yuv_in  = '0;
    rgb_in  = '0;
    do_reset();

    // mode 0 directed
    send_byte(8'h80); send_byte(8'h80); send_byte(8'h80); send_byte(8'hFF);
    idle(2);
    check_rgb_log(24'h808080, 24'hFFFFFF);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
    idle(2);
    check_rgb_log(24'hB20000, 24'hB20000);

    // mode 0 random with gaps
    for (int i = 0; i < 40; i++) begin
      send_byte(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    obs_rgb_q.delete();

    // mode 1 directed
    op_mode = 1'b1;
    idle(4);
    send_pix(24'hFFFFFF); send_pix(24'hFFFFFF);
    idle(8);
    check_yuv_log(8'h80, 8'hFF, 8'h80, 8'hFF);
    send_pix(24'h000000); send_pix(24'h000000);
    idle(8);
    check_yuv_log(8'h80, 8'h00, 8'h80, 8'h00);

    // mode 1 streaming with in_en held high
    busy_toggles = 0;
    for (int i = 0; i < 500; i++) send_pix((3*DW)'($urandom()));
    idle(12);
    check("stream_bytes", obs_yuv_q.size(), 1000);
    check("stream_left", exp_q.size(), 0);
    check("stream_busy_toggles", busy_toggles > 1, 1);
    obs_yuv_q.delete();
    obs_cyc_q.delete();

    // mode 1 random with gaps
    for (int i = 0; i < 20; i++) begin
      send_pix((3*DW)'($urandom()));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    obs_yuv_q.delete();
    obs_cyc_q.delete();

    // switch 1 -> 0 while the FIFO still holds bytes
    send_pix((3*DW)'($urandom()));
    send_pix((3*DW)'($urandom()));
    op_mode = 1'b0;
    in_en   = 1'b0;
    tick(t);
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      check("switch_busy_drain", busy, 1);
      tick(t);
      n++;
    end
    n = 0;
    while (busy && n < 10) begin tick(t); n++; end
    check("switch_busy_release", busy, 0);
    check("switch_drained", obs_yuv_q.size(), 4);
    obs_yuv_q.delete();
    obs_cyc_q.delete();
    send_byte(8'h80); send_byte(8'h80); send_byte(8'h80); send_byte(8'hFF);
    idle(2);
    check_rgb_log(24'h808080, 24'hFFFFFF);

    // reset mid-pixel in mode 0
    send_byte(8'h80); send_byte(8'h12);
    do_reset();
    send_byte(8'h80); send_byte(8'h80); send_byte(8'h80); send_byte(8'h80);
    idle(2);
    check_rgb_log(24'h808080, 24'h808080);

    // reset mid-drain in mode 1, after an odd pixel count
    op_mode = 1'b1;
    idle(3);
    send_pix(24'h123456); send_pix(24'hABCDEF); send_pix(24'h00FF00);
    idle(1);
    check("pre_reset_valid", out_valid, 1);
    do_reset();
    obs_yuv_q.delete();
    obs_cyc_q.delete();
    send_pix(24'hFFFFFF); send_pix(24'h000000);
    idle(8);
    check_yuv_log(8'h80, 8'hFF, 8'h80, 8'h00);

    idle(4);
    check("end_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cte_param.md
CTE_PARAM -- requirements
Module: cte_param

Interface
REQ-001 The block SHALL have parameter DW, default 8: bits per colour component.
REQ-002 The block SHALL have parameter DEPTH, default 4 (legal ≥4): output FIFO entries of DW bits, used in mode 1.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port op_mode, input, 1: requested mode; 0 = YUV422→RGB, 1 = RGB→YUV422.
REQ-006 The block SHALL have port in_en, input, 1: input data valid.
REQ-007 The block SHALL have port yuv_in, input, DW: mode-0 byte stream, order U,Y0,V,Y1 repeating.
REQ-008 The block SHALL have port rgb_in, input, 3*DW: mode-1 pixel {R,G,B}, R in the MSBs.
REQ-009 The block SHALL have port busy, output, 1: input not accepted this cycle.
REQ-010 The block SHALL have port out_valid, output, 1: rgb_out or yuv_out carries a result.
REQ-011 The block SHALL have port rgb_out, output, 3*DW: mode-0 result {R,G,B}.
REQ-012 The block SHALL have port yuv_out, output, DW: mode-1 result byte, order U,Y0,V,Y1.

Function
REQ-013 A transfer SHALL occur on a rising edge where in_en=1 and busy=0; no other input is consumed.
REQ-014 The block SHALL hold an internal mode register and a 2-bit phase counter; the counter advances per transfer and wraps 3→0 in mode 0, 1→0 in mode 1.
REQ-015 The mode register SHALL load op_mode only when phase=0, the pipeline is empty and the FIFO is empty.
REQ-016 While op_mode differs from the mode register, busy SHALL be 1 until the block drains and the new mode loads.
REQ-017 In mode 0, with O=2^(DW-1) and d=U-O, e=V-O (signed): R=Y+((359e+128)>>>8), G=Y+((-88d-183e+128)>>>8), B=Y+((454d+128)>>>8); each component SHALL clamp to [0, 2^DW-1].
REQ-018 In mode 0, pixel 0 SHALL complete on the V transfer (using stored U,Y0) and pixel 1 on the Y1 transfer.
REQ-019 In mode 0, rgb_out and out_valid SHALL be registered, valid for exactly one cycle starting one cycle after the completing transfer, and busy SHALL be 0 except per REQ-016.
REQ-020 In mode 1: Y=(77R+150G+29B+128)>>8, U=((-43R-85G+128B+128)>>>8)+O, V=((128R-107G-21B+128)>>>8)+O, each clamped; U and V SHALL be taken from the even pixel only.
REQ-021 In mode 1, each transfer SHALL enter a one-stage register; the next cycle it SHALL push two bytes into the FIFO (even pixel: U then Y0; odd pixel: V then Y1).
REQ-022 In mode 1, out_valid SHALL equal FIFO non-empty and yuv_out the FIFO head, popping one entry per cycle; a simultaneous push and pop SHALL be legal.
REQ-023 In mode 1, busy SHALL be 1 when count + 2·stage_valid ≥ DEPTH-1, so that the FIFO never overflows.
REQ-024 Outputs not belonging to the active mode SHALL be driven to 0.

Reset
REQ-025 On reset=1, phase, stage, FIFO pointers and count, busy, out_valid, rgb_out and yuv_out SHALL clear to 0 immediately, and the mode register SHALL load op_mode.
REQ-026 Assertion of reset mid-pixel or mid-drain SHALL discard partial data, and the first transfer after release SHALL be treated as U (mode 0) or an even pixel (mode 1).

Verification
REQ-027 The bench SHALL check: mode 0, bytes 80,80,80,FF → rgb_out 808080 then FFFFFF, each one cycle after the V and Y1 transfers respectively.
REQ-028 The bench SHALL check: mode 0, bytes 80,00,FF,00 → rgb_out B20000 twice (G and B clamp to 0).
REQ-029 The bench SHALL check: mode 1, pixels FFFFFF,FFFFFF → yuv_out 80,FF,80,FF on consecutive cycles; pixels 000000,000000 → 80,00,80,00.
REQ-030 The bench SHALL check: mode 1, DEPTH=4, in_en held at 1 for 500 pixels → busy toggles, there is no overflow and no lost byte, and 1000 bytes are output in order.
REQ-031 The bench SHALL check: op_mode switched 1→0 with the FIFO holding 3 bytes → busy stays 1 until the 3 bytes drain, then the mode-0 stream is accepted with phase=U.
REQ-032 The bench SHALL check: reset pulsed after a U,Y0 transfer → all outputs 0 immediately, and the next stream 80,80,80,80 yields rgb_out 808080 twice.
